// File: rtl/spi_slave_core.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_core
// Description : Byte-oriented SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first.
//               sclk/mosi/ss are oversampled through synchronizer chains on
//               ext_clk. Received words are presented with a one-cycle
//               strobe; send_data is shifted out on miso.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_core #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             ext_clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             ss,
  input  logic [WIDTH-1:0] send_data,
  output logic             send_ready,
  output logic [WIDTH-1:0] recv_data,
  output logic             recv_ready
);

  localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int            FW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  // Cycles needed for reset values to drain out of the synchronizer chain
  localparam logic [FW-1:0] FLUSH_LEN = FW'(SYNC_STAGES + 1);

  // WAIT: after reset, until ss is genuinely seen high; IDLE: ss high;
  // ACTIVE: inside an ss-low frame
  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;
  logic                   sclk_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   ss_fall;

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [FW-1:0]          flush_q;
  logic [FW-1:0]          flush_d;
  logic                   flush_done;

  logic                   start;
  logic                   abort;
  logic                   bit_rise;
  logic                   bit_fall;
  logic                   word_done;

  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [WIDTH-1:0]       rx_q;
  logic [WIDTH-1:0]       rx_d;
  logic [WIDTH-1:0]       tx_q;
  logic [WIDTH-1:0]       tx_d;
  logic                   miso_q;
  logic                   miso_d;
  logic [WIDTH-1:0]       recv_data_q;
  logic [WIDTH-1:0]       recv_data_d;
  logic                   recv_ready_q;
  logic                   recv_ready_d;

  // Synchronizer chains plus one extra sample for edge detection
  always_ff @(posedge ext_clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  assign flush_done = (flush_q == FLUSH_LEN);

  // State register and post-reset flush counter
  always_ff @(posedge ext_clk) begin
    if (rst) begin
      state_q <= ST_WAIT;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic; a frame already open at reset release is ignored
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    case (state_q)
      ST_WAIT: begin
        if (!flush_done) begin
          flush_d = flush_q + FW'(1);
        end else if (ss_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (ss_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Per-cycle control events derived from state and synchronized edges
  always_comb begin
    start     = (state_q == ST_IDLE) && ss_fall;
    abort     = (state_q == ST_ACTIVE) && ss_s;
    bit_rise  = (state_q == ST_ACTIVE) && !ss_s && sclk_rise;
    bit_fall  = (state_q == ST_ACTIVE) && !ss_s && sclk_fall && (cnt_q != '0);
    word_done = bit_rise && (cnt_q == CNT_LAST);
  end

  // Datapath next-state: shift, count, complete words, drive miso
  always_comb begin
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    recv_data_d  = recv_data_q;
    recv_ready_d = 1'b0;
    if (start) begin
      cnt_d  = '0;
      tx_d   = send_data;
      miso_d = send_data[WIDTH-1];
    end else if (abort) begin
      cnt_d  = '0;
      rx_d   = '0;
      miso_d = 1'b0;
    end else if (bit_rise) begin
      rx_d = {rx_q[WIDTH-2:0], mosi_s};
      if (word_done) begin
        cnt_d        = '0;
        recv_data_d  = {rx_q[WIDTH-2:0], mosi_s};
        recv_ready_d = 1'b1;
        // Reload so back-to-back words in one frame need no gap
        tx_d         = send_data;
        miso_d       = send_data[WIDTH-1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (bit_fall) begin
      tx_d   = {tx_q[WIDTH-2:0], 1'b0};
      miso_d = tx_q[WIDTH-2];
    end
  end

  // Datapath registers
  always_ff @(posedge ext_clk) begin
    if (rst) begin
      cnt_q        <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
      recv_data_q  <= '0;
      recv_ready_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      recv_data_q  <= recv_data_d;
      recv_ready_q <= recv_ready_d;
    end
  end

  assign miso       = miso_q;
  assign recv_data  = recv_data_q;
  assign recv_ready = recv_ready_q;
  assign send_ready = ss_s | (cnt_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_slave_core
// Description : Bench acting as SPI master for spi_slave_core, with a
//               word-level expectation queue and randomized frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss = 1'b1;
  logic [7:0] send_data = 8'h00;
  logic       miso;
  logic       send_ready;
  logic [7:0] recv_data;
  logic       recv_ready;

  spi_slave_core #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .ext_clk    (clk),
    .rst        (rst),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .ss         (ss),
    .send_data  (send_data),
    .send_ready (send_ready),
    .recv_data  (recv_data),
    .recv_ready (recv_ready)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         half = 5;
  logic [7:0] nxt_send;
  logic [7:0] mb[4];
  logic [7:0] mid[4];
  logic [7:0] first_got;
  logic [7:0] seq[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2ns after the rising edge, well clear of DUT sampling
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Compare process: every strobe must match the next completed master word,
  // strobes last one cycle, and an idle slave keeps miso low / send_ready high
  logic prev_rdy = 1'b0;
  int   ss_hi = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (recv_ready) begin
        check("strobe_width", prev_rdy, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: recv_data=%0h, no word expected at %0t", recv_data, $time);
        end else begin
          check("recv_data", recv_data, exp_q.pop_front());
        end
      end
      if (ss_hi >= 4) begin
        check("miso_idle", miso, 0);
        check("send_ready_idle", send_ready, 1);
      end
    end
    prev_rdy = recv_ready;
    ss_hi    = ss ? ss_hi + 1 : 0;
  end

  // One ss-low frame of nw words: mb[] on mosi; miso must return the
  // send_data present at frame start, then mid[w] written during word w
  task automatic do_frame(input int nw);
    logic [7:0] exp_tx;
    logic [7:0] got;
    bit         seen;
    int         lat;
    exp_tx = send_data;
    ss = 1'b0;
    for (int w = 0; w < nw; w++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        mosi = mb[w][7-i];
        tick(half);
        if (i == 3 && w < nw - 1) begin
          check("send_ready_busy", send_ready, 0);
          send_data = mid[w];
        end
        sclk = 1'b1;
        got = {got[6:0], miso};
        if (i == 7) begin
          exp_q.push_back(mb[w]);
          seen = 1'b0;
          lat  = 0;
          for (int k = 1; k <= half; k++) begin
            tick(1);
            if (recv_ready && !seen) begin
              seen = 1'b1;
              lat  = k;
              if (w == nw - 1) begin
                check("send_ready_strobe", send_ready, 1);
                send_data = nxt_send;
              end
            end
          end
          if (!seen || lat > 4) begin
            total++;
            bad++;
            $display("FAIL strobe_latency: seen=%0d cycles=%0d, required within 4", seen, lat);
          end else begin
            total++;
          end
        end else begin
          tick(half);
        end
        sclk = 1'b0;
      end
      if (w == 0) first_got = got;
      check("miso_word", got, exp_tx);
      exp_tx = mid[w];
    end
    tick(half);
    ss = 1'b1;
    tick(8);
  endtask

  // Partial word then ss high; optionally pulse rst mid-word and keep
  // clocking with ss low, which must be ignored until a fresh ss fall
  task automatic partial(input int nb, input bit do_rst);
    ss = 1'b0;
    tick(half);
    for (int i = 0; i < nb; i++) begin
      mosi = 1'($urandom);
      tick(half);
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
    if (do_rst) begin
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      check("rst_recv_data", recv_data, 0);
      check("rst_recv_ready", recv_ready, 0);
      for (int i = 0; i < 10; i++) begin
        mosi = 1'($urandom);
        tick(half);
        sclk = 1'b1;
        tick(half);
        sclk = 1'b0;
      end
    end
    tick(half);
    ss = 1'b1;
    tick(8);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_recv_data", recv_data, 0);
    check("reset_recv_ready", recv_ready, 0);
    check("reset_miso", miso, 0);
    check("reset_send_ready", send_ready, 1);
    tick(4);

    // sclk toggling with ss high must produce nothing
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      tick(half);
    end
    sclk = 1'b0;
    tick(4);
    check("idle_recv_data", recv_data, 0);

    // Single frame, transmit 0x01, then 0x02 written at the strobe
    send_data = 8'h01;
    nxt_send  = 8'h02;
    mb[0]     = 8'h02;
    do_frame(1);
    check("lit_rx_02", recv_data, 8'h02);
    check("lit_tx_01", first_got, 8'h01);

    // Sequential one-byte frames
    seq[0] = 8'h02; seq[1] = 8'h01; seq[2] = 8'hFF; seq[3] = 8'h03;
    for (int j = 0; j < 4; j++) begin
      mb[0]    = seq[j];
      nxt_send = 8'($urandom);
      do_frame(1);
      check("lit_seq", recv_data, seq[j]);
      if (j == 0) check("lit_tx_02", first_got, 8'h02);
    end

    // Two words in one frame
    send_data = 8'h5A;
    mid[0]    = 8'hC3;
    mb[0]     = 8'hA5;
    mb[1]     = 8'h3C;
    nxt_send  = 8'h00;
    do_frame(2);
    check("lit_two_words", recv_data, 8'h3C);

    // Abort by ss, then by rst
    partial(5, 1'b0);
    mb[0] = 8'h81;
    do_frame(1);
    check("lit_after_ss_abort", recv_data, 8'h81);
    partial(5, 1'b1);
    mb[0] = 8'h81;
    do_frame(1);
    check("lit_after_rst_abort", recv_data, 8'h81);

    // Randomized frames
    repeat (14) begin
      half = $urandom_range(4, 7);
      if ($urandom_range(0, 3) == 0) partial($urandom_range(1, 7), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) begin
        mb[i]  = 8'($urandom);
        mid[i] = 8'($urandom);
      end
      nxt_send = 8'($urandom);
      do_frame($urandom_range(1, 3));
    end
    half = 5;

    tick(20);
    check("pending_words", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
